// File: rtl/game_pkg.sv
// Shared encodings for the game pipeline: keys, pages, soul opcodes, instruction fields.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package game_pkg;

  // Keyboard codes delivered by the input decoder
  localparam logic [2:0] KEY_NONE  = 3'd0;
  localparam logic [2:0] KEY_W     = 3'd1;
  localparam logic [2:0] KEY_D     = 3'd2;
  localparam logic [2:0] KEY_S     = 3'd3;
  localparam logic [2:0] KEY_A     = 3'd4;
  localparam logic [2:0] KEY_SPACE = 3'd5;

  // Screen pages driven by the game state machine
  localparam logic [2:0] PAGE_NULL   = 3'd0;
  localparam logic [2:0] PAGE_MENU   = 3'd1;
  localparam logic [2:0] PAGE_START  = 3'd2;
  localparam logic [2:0] PAGE_DODGE  = 3'd3;
  localparam logic [2:0] PAGE_ATTACK = 3'd4;
  localparam logic [2:0] PAGE_ACTION = 3'd5;

  // Soul opcodes carried in instr[15:12]
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_HPY = 4'd1;
  localparam logic [3:0] OP_DPY = 4'd2;
  localparam logic [3:0] OP_IDG = 4'd3;
  localparam logic [3:0] OP_SDG = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_SHP = 4'd6;

  // MOV operand directions
  localparam logic [7:0] DIR_UP    = 8'd0;
  localparam logic [7:0] DIR_LEFT  = 8'd1;
  localparam logic [7:0] DIR_DOWN  = 8'd2;
  localparam logic [7:0] DIR_RIGHT = 8'd3;

  // Instruction field boundaries
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int OPD_HI = 11;
  localparam int OPD_LO = 4;
  localparam int AUX_HI = 3;
  localparam int AUX_LO = 0;

  typedef struct packed {
    logic [3:0] opc;
    logic [7:0] opd;
    logic [3:0] aux;
  } instr_t;

  // Step toward a lower bound; the compare happens before the subtract so it never wraps
  function automatic logic [9:0] step_dec(input logic [9:0] pos, input logic [9:0] lo,
                                          input logic [9:0] step);
    if ({1'b0, pos} >= ({1'b0, lo} + {1'b0, step})) return pos - step;
    else return lo;
  endfunction

  // Step toward an upper bound with an 11-bit sum so the compare cannot overflow
  function automatic logic [9:0] step_inc(input logic [9:0] pos, input logic [9:0] hi,
                                          input logic [9:0] step);
    if (({1'b0, pos} + {1'b0, step}) <= {1'b0, hi}) return pos + step;
    else return hi;
  endfunction

endpackage

// File: rtl/load_down_counter.sv
// Loadable down counter that parks at zero; exposes its value and a zero flag.
// Latency: load visible one cycle after the edge; otherwise decrements once per cycle.
// Backpressure: none; load always wins over the decrement.
module load_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  // Load takes priority; otherwise count down until zero and hold there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/soul_executor.sv
// Executes soul opcodes: HP set/damage/heal, dodge enter/leave, rate-limited moves in the box.
// Latency: effects appear on outputs one cycle after the accept edge.
// Backpressure: instrReady is low while the post-MOV cooldown counter is nonzero.
module soul_executor
  import game_pkg::*;
#(
  parameter int MAX_HP        = 20,
  parameter int X_MIN         = 200,
  parameter int X_MAX         = 440,
  parameter int Y_MIN         = 240,
  parameter int Y_MAX         = 400,
  parameter int STEP          = 4,
  parameter int MOVE_COOLDOWN = 250000,
  parameter int INV_CYCLES    = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instrValid,
  output logic        instrReady,
  output logic [9:0]  posX,
  output logic [9:0]  posY,
  output logic [7:0]  hp,
  output logic        isDeath,
  output logic        invincible,
  output logic        dodging
);

  localparam int CD_W  = $clog2(MOVE_COOLDOWN + 1);
  localparam int INV_W = $clog2(INV_CYCLES + 1);

  localparam logic [7:0] HP_MAX = 8'(MAX_HP);
  localparam logic [9:0] XLO    = 10'(X_MIN);
  localparam logic [9:0] XHI    = 10'(X_MAX);
  localparam logic [9:0] YLO    = 10'(Y_MIN);
  localparam logic [9:0] YHI    = 10'(Y_MAX);
  localparam logic [9:0] XC     = 10'((X_MIN + X_MAX) / 2);
  localparam logic [9:0] YC     = 10'((Y_MIN + Y_MAX) / 2);
  localparam logic [9:0] STP    = 10'(STEP);

  localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(MOVE_COOLDOWN);
  localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INV_CYCLES);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DODGE = 2'd1;
  localparam logic [1:0] ST_DEAD  = 2'd2;

  instr_t            ins;
  logic              accept;
  logic [1:0]        st, st_n;
  logic [7:0]        hp_n;
  logic [9:0]        x_n, y_n;
  logic [8:0]        heal_sum;
  logic              cd_load, cd_zero;
  logic [CD_W-1:0]   cd_val;
  logic              inv_load, inv_zero;
  logic [INV_W-1:0]  inv_ld_val, inv_val;

  assign ins    = instr_t'(instr);
  assign accept = instrValid & instrReady;

  // Decode the accepted opcode against the current state into next-state values
  always_comb begin
    st_n       = st;
    hp_n       = hp;
    x_n        = posX;
    y_n        = posY;
    heal_sum   = {1'b0, hp} + {1'b0, ins.opd};
    cd_load    = 1'b0;
    inv_load   = 1'b0;
    inv_ld_val = '0;
    if (accept) begin
      case (ins.opc)
        OP_HPY: begin
          hp_n = (ins.opd > HP_MAX) ? HP_MAX : ins.opd;
          if (hp_n == 8'd0)      st_n = ST_DEAD;
          else if (st == ST_DEAD) st_n = ST_IDLE;
        end
        OP_DPY: begin
          // A hit landing while the timer is still running (pre-edge value) is absorbed
          if (st != ST_DEAD && invincible == 1'b0) begin
            hp_n       = (ins.opd >= hp) ? 8'd0 : hp - ins.opd;
            inv_load   = 1'b1;
            inv_ld_val = INV_LOAD;
            if (hp_n == 8'd0) st_n = ST_DEAD;
          end
        end
        OP_IDG: begin
          if (st != ST_DEAD) begin
            st_n       = ST_DODGE;
            x_n        = XC;
            y_n        = YC;
            inv_load   = 1'b1;
            inv_ld_val = '0;
          end
        end
        OP_SDG: begin
          if (st == ST_DODGE) st_n = ST_IDLE;
        end
        OP_MOV: begin
          // Any MOV in DODGE arms the cooldown, even an unknown direction
          if (st == ST_DODGE) begin
            cd_load = 1'b1;
            case (ins.opd)
              DIR_UP:    y_n = step_dec(posY, YLO, STP);
              DIR_LEFT:  x_n = step_dec(posX, XLO, STP);
              DIR_DOWN:  y_n = step_inc(posY, YHI, STP);
              DIR_RIGHT: x_n = step_inc(posX, XHI, STP);
              default: ;
            endcase
          end
        end
        OP_SHP: begin
          if (st != ST_DEAD) hp_n = (heal_sum > {1'b0, HP_MAX}) ? HP_MAX : heal_sum[7:0];
        end
        default: ;
      endcase
    end
  end

  // Architectural state: FSM, HP and position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= ST_IDLE;
      hp   <= HP_MAX;
      posX <= XC;
      posY <= YC;
    end else begin
      st   <= st_n;
      hp   <= hp_n;
      posX <= x_n;
      posY <= y_n;
    end
  end

  load_down_counter #(.W(CD_W)) u_cooldown (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cd_load),
    .load_val (CD_LOAD),
    .value    (cd_val),
    .zero     (cd_zero)
  );

  load_down_counter #(.W(INV_W)) u_invincible (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (inv_load),
    .load_val (inv_ld_val),
    .value    (inv_val),
    .zero     (inv_zero)
  );

  assign instrReady = cd_zero;
  assign invincible = ~inv_zero;
  assign isDeath    = (st == ST_DEAD);
  assign dodging    = (st == ST_DODGE);

endmodule

// File: tb/tb_soul_executor.sv
// Scoreboard bench for soul_executor: expected outputs queued per instruction, checked after accept.
// Latency: compares outputs on the falling edge following each accept edge.
// Backpressure: waits on instrReady with a bounded cycle budget.
module tb_soul_executor;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] hp;
    logic       death;
    logic       inv;
    logic       dodge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = 16'h0;
  logic        instrValid = 1'b0;
  logic        instrReady;
  logic [9:0]  posX, posY;
  logic [7:0]  hp;
  logic        isDeath, invincible, dodging;

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb[$];
  exp_t e;
  logic acc_seen;

  soul_executor #(
    .X_MIN(199), .X_MAX(441), .MOVE_COOLDOWN(4), .INV_CYCLES(30)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .instrValid (instrValid),
    .instrReady (instrReady),
    .posX       (posX),
    .posY       (posY),
    .hp         (hp),
    .isDeath    (isDeath),
    .invincible (invincible),
    .dodging    (dodging)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
  endtask

  task automatic check_all(input string tag, input exp_t x);
    check({tag, ".posX"}, 32'(posX), 32'(x.x));
    check({tag, ".posY"}, 32'(posY), 32'(x.y));
    check({tag, ".hp"}, 32'(hp), 32'(x.hp));
    check({tag, ".isDeath"}, 32'(isDeath), 32'(x.death));
    check({tag, ".invincible"}, 32'(invincible), 32'(x.inv));
    check({tag, ".dodging"}, 32'(dodging), 32'(x.dodge));
  endtask

  // Record accept edges using pre-edge handshake values
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_seen <= 1'b0;
    else        acc_seen <= instrValid && instrReady;
  end

  // Pop one expectation per accept and compare on the following falling edge
  always @(negedge clk) begin
    if (acc_seen && rst_n) begin
      if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else check_all("sb", sb.pop_front());
    end
  end

  // Queue the expected result, present the instruction, wait for it to be taken
  task automatic send(input logic [15:0] ins, input exp_t x);
    int n;
    sb.push_back(x);
    @(negedge clk);
    instr      = ins;
    instrValid = 1'b1;
    n = 0;
    while (!instrReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    instrValid = 1'b0;
  endtask

  initial begin
    int cnt;
    e = '{x: 10'd320, y: 10'd320, hp: 8'd20, death: 1'b0, inv: 1'b0, dodge: 1'b0};
    repeat (3) @(negedge clk);
    check_all("reset", e);
    check("reset.ready", 32'(instrReady), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Enter dodge, then a held MOV RIGHT pair across the cooldown
    e.dodge = 1'b1;
    send(16'h3000, e);
    e.x = 10'd324; sb.push_back(e);
    e.x = 10'd328; sb.push_back(e);
    @(negedge clk);
    check("mov1.ready_before", 32'(instrReady), 32'd1);
    instr = 16'h5030; instrValid = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (!instrReady && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    check("mov.cooldown_len", 32'(cnt), 32'd4);
    @(negedge clk);
    instrValid = 1'b0;

    // Walk left to X_MIN+1, then clamp without wrapping
    for (int i = 0; i < 32; i++) begin
      e.x = e.x - 10'd4;
      send(16'h5010, e);
    end
    check("walk.x", 32'(posX), 32'd200);
    e.x = 10'd199; send(16'h5010, e);
    send(16'h5010, e);

    // Down to Y_MAX and clamp there
    for (int i = 0; i < 21; i++) begin
      if (e.y < 10'd400) e.y = e.y + 10'd4;
      send(16'h5020, e);
    end
    send(16'h5070, e);
    check("mov_bad.ready", 32'(instrReady), 32'd0);

    // Leave dodge; MOV in IDLE has no effect and no cooldown
    e.dodge = 1'b0;
    send(16'h4000, e);
    send(16'h5030, e);
    check("mov_idle.ready", 32'(instrReady), 32'd1);

    // Damage and invincibility window
    e.hp = 8'd15; e.inv = 1'b1; send(16'h2050, e);
    send(16'h2050, e);
    repeat (40) @(negedge clk);
    check("inv.expired", 32'(invincible), 32'd0);
    e.hp = 8'd10; send(16'h2050, e);
    e.hp = 8'd3;  send(16'h1030, e);
    repeat (40) @(negedge clk);
    e.inv = 1'b0;
    check("inv.expired2", 32'(invincible), 32'd0);

    // Lethal hit, dead-state filtering, revive
    e.hp = 8'd0; e.death = 1'b1; e.inv = 1'b1; send(16'h2090, e);
    send(16'h6050, e);
    send(16'h3000, e);
    e.hp = 8'd7; e.death = 1'b0; send(16'h1070, e);
    check("revive.dodging", 32'(dodging), 32'd0);

    // Heal and set saturate at MAX_HP
    e.hp = 8'd18; send(16'h1120, e);
    e.hp = 8'd20; send(16'h60A0, e);
    send(16'h1FF0, e);
    repeat (40) @(negedge clk);
    e.inv = 1'b0;

    // Build hp=4, invincible, mid-cooldown, then reset
    e.hp = 8'd4; send(16'h1040, e);
    e.dodge = 1'b1; e.x = 10'd320; e.y = 10'd320; send(16'h3000, e);
    e.inv = 1'b1; send(16'h2000, e);
    e.y = 10'd316; send(16'h5000, e);
    check("pre_rst.ready", 32'(instrReady), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    e = '{x: 10'd320, y: 10'd320, hp: 8'd20, death: 1'b0, inv: 1'b0, dodge: 1'b0};
    check_all("rst", e);
    check("rst.ready", 32'(instrReady), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all("post_rst", e);

    check("sb.drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
